// File: rtl/imm_pack_pkg.sv
// ---------------------------------------------------------------------------
// imm_pack_pkg
// Shared definitions for the immediate extender / immediate packer pair.
//   imm_src_e    : immediate format selector (I/S/B/J), same coding as the
//                  extender's immsrc input
//   pack_entry_t : one output buffer entry {instr, immErr}
//   FIFO_DEPTH   : number of entries in the packer's output buffer
//   isSignRun    : true when bits [31:lsb] of a word are all equal
// ---------------------------------------------------------------------------
package imm_pack_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        immErr;
    } pack_entry_t;

    localparam int FIFO_DEPTH = 2;

    // An arithmetic shift by lsb leaves all-zeros or all-ones exactly when
    // every bit from lsb up to 31 matches the sign bit.
    function automatic logic isSignRun(input logic [31:0] value, input int lsb);
        logic signed [31:0] shifted;
        shifted = $signed(value) >>> lsb;
        return (shifted == '0) || (shifted == '1);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// ---------------------------------------------------------------------------
// imm_scatter
// Combinational inverse of the immediate extender: scatters a sign-extended
// immediate into the I/S/B/J bit positions of a template instruction and
// flags immediates that the selected format cannot represent.
// Ports:
//   immsrc  (in, 2)  : format select, coded as imm_src_e
//   imm     (in, 32) : sign-extended immediate
//   base    (in, 32) : template instruction supplying all non-immediate bits
//   instr   (out, 32): packed instruction (truncated packing on overflow)
//   imm_err (out, 1) : immediate not representable in the selected format
// ---------------------------------------------------------------------------
module imm_scatter
    import imm_pack_pkg::*;
(
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        imm_err
);

    // Start from the template so every bit outside the immediate field keeps
    // its opcode/register/funct value, then overwrite only the immediate
    // positions of the chosen format. B and J drop imm[0] because branch and
    // jump offsets are always even, which is why an odd offset is an error.
    always_comb begin
        instr   = base;
        imm_err = 1'b0;
        case (imm_src_e'(immsrc))
            IMM_I: begin
                instr[31:20] = imm[11:0];
                imm_err      = !isSignRun(imm, 11);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                imm_err      = !isSignRun(imm, 11);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                imm_err      = imm[0] || !isSignRun(imm, 12);
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                imm_err      = imm[0] || !isSignRun(imm, 20);
            end
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// ---------------------------------------------------------------------------
// imm_pack
// Immediate packer with a valid/ready stream interface. Each accepted beat is
// packed by imm_scatter and stored in a 2-entry output FIFO; the head entry
// drives the outputs. Saturating counters track accepted beats and accepted
// beats whose immediate was not representable.
// Ports:
//   clk, reset_n          : rising-edge clock, async active-low reset
//   flush                 : sync clear of FIFO and both counters
//   in_valid / in_ready   : input handshake (in_ready depends on state only)
//   immsrc, imm, base     : format select, immediate, template instruction
//   out_valid / out_ready : output handshake
//   instr, imm_err        : head entry of the FIFO
//   pkt_count, err_count  : saturating beat / error counters
// ---------------------------------------------------------------------------
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       immsrc,
    input  logic [31:0]      imm,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             imm_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    pack_entry_t      r_mem [FIFO_DEPTH];
    logic             r_wrPtr;
    logic             r_rdPtr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_pktCount;
    logic [CNT_W-1:0] r_errCount;

    logic [31:0]      w_packedInstr;
    logic             w_packedErr;
    logic             w_push;
    logic             w_pop;

    imm_scatter u_scatter (
        .immsrc  (immsrc),
        .imm     (imm),
        .base    (base),
        .instr   (w_packedInstr),
        .imm_err (w_packedErr)
    );

    // Both handshakes look only at the registered occupancy, so a full
    // buffer refuses a beat even when the head is leaving this cycle.
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign instr     = r_mem[r_rdPtr].instr;
    assign imm_err   = r_mem[r_rdPtr].immErr;
    assign pkt_count = r_pktCount;
    assign err_count = r_errCount;

    // FIFO storage, pointers, occupancy and counters. Storage is cleared on
    // reset so the outputs read zero until the first beat arrives. A flush
    // wins over any handshake in the same cycle; that beat is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_pktCount <= '0;
            r_errCount <= '0;
        end else if (flush) begin
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_pktCount <= '0;
            r_errCount <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= '{instr: w_packedInstr, immErr: w_packedErr};
                r_wrPtr        <= ~r_wrPtr;
                if (r_pktCount != '1) begin
                    r_pktCount <= r_pktCount + 1'b1;
                end
                if (w_packedErr && (r_errCount != '1)) begin
                    r_errCount <= r_errCount + 1'b1;
                end
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// ---------------------------------------------------------------------------
// tb_imm_pack
// Self-checking bench for imm_pack: a table of directed packing vectors, a
// few hand-written handshake / flush / reset sequences, and a randomized run
// scored against a queue-based reference model with an independent extender.
// ---------------------------------------------------------------------------
module tb_imm_pack;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       immsrc;
    logic [31:0]      imm;
    logic [31:0]      base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             imm_err;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] expInstr;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } beat_t;

    imm_pack #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .immsrc    (immsrc),
        .imm       (imm),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .imm_err   (imm_err),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after
    // the rising edge, well away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] src,
                                 input logic [31:0] value, input logic [31:0] tmpl);
        in_valid = valid;
        immsrc   = src;
        imm      = value;
        base     = tmpl;
    endtask

    // Reference packing: copy the template, then overwrite the immediate
    // fields of the chosen format bit-group by bit-group.
    function automatic logic [31:0] modelPack(input logic [1:0] src,
                                              input logic [31:0] v,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = b;
        case (src)
            2'b00: r[31:20] = v[11:0];
            2'b01: begin
                r[31:25] = v[11:5];
                r[11:7]  = v[4:0];
            end
            2'b10: begin
                r[31]    = v[12];
                r[30:25] = v[10:5];
                r[11:8]  = v[4:1];
                r[7]     = v[11];
            end
            default: begin
                r[31]    = v[20];
                r[30:21] = v[10:1];
                r[20]    = v[11];
                r[19:12] = v[19:12];
            end
        endcase
        return r;
    endfunction

    // Reference representability: signed range of each format, plus even
    // alignment for branch and jump offsets.
    function automatic logic modelErr(input logic [1:0] src, input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        case (src)
            2'b00, 2'b01: return (s < -2048) || (s > 2047);
            2'b10:        return (s < -4096) || (s > 4095) || v[0];
            default:      return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || v[0];
        endcase
    endfunction

    // Reference extender: reassemble the signed immediate field of the
    // format and sign-extend it to 32 bits.
    function automatic logic [31:0] modelExtend(input logic [1:0] src, input logic [31:0] ins);
        logic signed [11:0] f12;
        logic signed [12:0] f13;
        logic signed [20:0] f21;
        int r;
        case (src)
            2'b00: begin
                f12 = ins[31:20];
                r   = f12;
            end
            2'b01: begin
                f12 = {ins[31:25], ins[11:7]};
                r   = f12;
            end
            2'b10: begin
                f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                r   = f13;
            end
            default: begin
                f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                r   = f21;
            end
        endcase
        return r;
    endfunction

    initial begin
        vec_t  vecs[9];
        beat_t q[$];
        int    expPkt;
        int    expErr;

        // Directed vectors: test-plan cases plus I and J range boundaries.
        vecs[0] = '{2'b00, 32'h0000_0678, 32'h0000_0093, 32'h6780_0093, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_2023, 32'hFE00_2E23, 1'b0};
        vecs[2] = '{2'b10, 32'h0000_0800, 32'h0000_0063, 32'h0000_00E3, 1'b0};
        vecs[3] = '{2'b10, 32'h0000_0801, 32'h0000_0063, 32'h0000_00E3, 1'b1};
        vecs[4] = '{2'b11, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
        vecs[5] = '{2'b11, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0};
        vecs[6] = '{2'b00, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
        vecs[7] = '{2'b00, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
        vecs[8] = '{2'b11, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0};

        // Power-up: hold reset and check the cleared outputs.
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
        #12;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset instr", instr, 32'h0);
        checkOutput("reset imm_err", {31'b0, imm_err}, 32'h0);
        checkOutput("reset pkt_count", 32'(pkt_count), 32'h0);
        checkOutput("reset err_count", 32'(err_count), 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'h1);
        step();

        // Table-driven single-beat pass-through with out_ready held high.
        out_ready = 1'b1;
        expPkt    = 0;
        expErr    = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].src, vecs[i].imm, vecs[i].base);
            step();
            in_valid = 1'b0;
            expPkt++;
            if (vecs[i].expErr) expErr++;
            checkOutput($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
            checkOutput($sformatf("vec%0d instr", i), instr, vecs[i].expInstr);
            checkOutput($sformatf("vec%0d imm_err", i), {31'b0, imm_err}, {31'b0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d pkt_count", i), 32'(pkt_count), 32'(expPkt));
            checkOutput($sformatf("vec%0d err_count", i), 32'(err_count), 32'(expErr));
            step();
            checkOutput($sformatf("vec%0d drained", i), {31'b0, out_valid}, 32'h0);
        end

        // Backpressure: fill the buffer, confirm the third beat is refused,
        // then drain in order including a push+pop at occupancy one.
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 32'h1, 32'h13);
        step();
        checkOutput("bp1 in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("bp1 instr", instr, 32'h0010_0013);
        applyStimulus(1'b1, 2'b00, 32'h2, 32'h13);
        step();
        checkOutput("bp2 in_ready", {31'b0, in_ready}, 32'h0);
        checkOutput("bp2 instr held", instr, 32'h0010_0013);
        applyStimulus(1'b1, 2'b00, 32'h3, 32'h13);
        step();
        checkOutput("bp3 in_ready", {31'b0, in_ready}, 32'h0);
        checkOutput("bp3 instr held", instr, 32'h0010_0013);
        checkOutput("bp3 pkt_count", 32'(pkt_count), 32'h2);
        out_ready = 1'b1;
        step();
        checkOutput("bp4 instr B", instr, 32'h0020_0013);
        checkOutput("bp4 pkt_count", 32'(pkt_count), 32'h2);
        checkOutput("bp4 in_ready", {31'b0, in_ready}, 32'h1);
        step();
        checkOutput("bp5 instr C", instr, 32'h0030_0013);
        checkOutput("bp5 out_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("bp5 in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("bp5 pkt_count", 32'(pkt_count), 32'h3);
        in_valid = 1'b0;
        step();
        checkOutput("bp6 out_valid", {31'b0, out_valid}, 32'h0);

        // Flush with two beats buffered and a beat offered the same cycle.
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 32'h800, 32'h13);
        step();
        step();
        checkOutput("flush pre err_count", 32'(err_count), 32'h2);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("flush pkt_count", 32'(pkt_count), 32'h0);
        checkOutput("flush err_count", 32'(err_count), 32'h0);
        checkOutput("flush in_ready", {31'b0, in_ready}, 32'h1);

        // Asynchronous reset pulse between edges with two beats buffered.
        applyStimulus(1'b1, 2'b00, 32'h800, 32'h13);
        step();
        step();
        in_valid = 1'b0;
        checkOutput("rst pre err_count", 32'(err_count), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst instr", instr, 32'h0);
        checkOutput("rst imm_err", {31'b0, imm_err}, 32'h0);
        checkOutput("rst pkt_count", 32'(pkt_count), 32'h0);
        checkOutput("rst err_count", 32'(err_count), 32'h0);
        checkOutput("rst in_ready", {31'b0, in_ready}, 32'h1);
        #1;
        reset_n = 1'b1;
        step();

        // Randomized stream scored against the queue model; the small
        // counter width makes saturation part of this run.
        expPkt = 0;
        expErr = 0;
        for (int n = 0; n < 1000; n++) begin
            logic              vld;
            logic              push;
            logic              pop;
            logic [1:0]        src;
            logic [31:0]       raw;
            logic signed [31:0] t;
            logic [31:0]       value;
            int                w;
            beat_t             bt;

            vld = ($urandom_range(0, 3) != 0);
            src = 2'($urandom_range(0, 3));
            w   = $urandom_range(1, 32);
            raw = $urandom;
            t   = raw << (32 - w);
            value = t >>> (32 - w);
            if ($urandom_range(0, 1) == 1) value[0] = 1'b0;
            applyStimulus(vld, src, value, $urandom);
            out_ready = ($urandom_range(0, 2) != 0);

            checkOutput("rnd out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            checkOutput("rnd in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            if (q.size() != 0) begin
                checkOutput("rnd instr", instr, q[0].instr);
                checkOutput("rnd imm_err", {31'b0, imm_err}, {31'b0, q[0].err});
                if (!q[0].err) begin
                    checkOutput("rnd roundtrip", modelExtend(q[0].src, instr), q[0].imm);
                end
            end
            checkOutput("rnd pkt_count", 32'(pkt_count), 32'(expPkt));
            checkOutput("rnd err_count", 32'(err_count), 32'(expErr));

            push = vld && (q.size() < 2);
            pop  = (q.size() != 0) && out_ready;
            step();
            if (pop) void'(q.pop_front());
            if (push) begin
                bt.src   = src;
                bt.imm   = value;
                bt.instr = modelPack(src, value, base);
                bt.err   = modelErr(src, value);
                q.push_back(bt);
                if (expPkt < CNT_MAX) expPkt++;
                if (bt.err && (expErr < CNT_MAX)) expErr++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
